// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART 8N1 program loader: count, little-endian word payload, 8-bit checksum
// Streams words into memory and holds the core in reset until a load completes cleanly.
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  prog_i,
    input  logic [DIV_WIDTH-1:0]  clks_per_bit_i,
    input  logic                  rx_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  prog_rst_no,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_e;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, RUN, ERROR} ld_state_e;

    logic rx_s1_q, rx_s1_d;
    logic rx_s2_q, rx_s2_d;
    logic rx_prev_q, rx_prev_d;

    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic                 byte_vld_q, byte_vld_d;
    logic                 frame_err_q, frame_err_d;
    logic [DIV_WIDTH-1:0] div_full;
    logic [DIV_WIDTH-1:0] div_half;

    ld_state_e             state_q, state_d;
    logic [7:0]            cnt_lo_q, cnt_lo_d;
    logic [15:0]           words_q, words_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [7:0]            csum_q, csum_d;
    logic                  done_q, done_d;
    logic                  prog_prev_q, prog_prev_d;
    logic                  prog_rise;
    logic                  csum_ok;
    logic                  loading;

    // Divisors below 2 would leave no room for a mid-bit re-check.
    always_comb begin
        div_full = (clks_per_bit_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clks_per_bit_i;
        div_half = div_full >> 1;
    end

    always_comb begin
        rx_s1_d     = rx_i;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = div_half - DIV_WIDTH'(1);
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
                end else if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_BITS;
                    rx_cnt_d   = div_full - DIV_WIDTH'(1);
                    rx_bit_d   = 4'd0;
                end
            end
            RX_BITS: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - DIV_WIDTH'(1);
                end else begin
                    rx_cnt_d = div_full - DIV_WIDTH'(1);
                    if (rx_bit_q == 4'd8) begin
                        rx_state_d  = RX_IDLE;
                        byte_vld_d  = rx_s2_q;
                        frame_err_d = !rx_s2_q;
                    end else begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        words_d     = words_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        csum_d      = csum_q;
        prog_prev_d = prog_i;
        prog_rise   = prog_i && !prog_prev_q;
        csum_ok     = 1'b0;
        loading     = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == DATA) || (state_q == CSUM);

        // Address advances the cycle after the strobe so it is stable while we_o is high.
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            IDLE: state_d = prog_i ? CNT_LO : RUN;
            CNT_LO: begin
                if (byte_vld_q) begin
                    cnt_lo_d = rx_shift_q;
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (byte_vld_q) begin
                    words_d = {rx_shift_q, cnt_lo_q};
                    idx_d   = '0;
                    state_d = ({rx_shift_q, cnt_lo_q} == 16'd0) ? CSUM : DATA;
                end
            end
            DATA: begin
                if (byte_vld_q) begin
                    asm_d[{idx_q, 3'b000} +: 8] = rx_shift_q;
                    csum_d = csum_q + rx_shift_q;
                    if (idx_q == LAST_IDX) begin
                        we_d    = 1'b1;
                        wdata_d = asm_d;
                        idx_d   = '0;
                        words_d = words_q - 16'd1;
                        if (words_q == 16'd1) begin
                            state_d = CSUM;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (byte_vld_q) begin
                    csum_ok = (rx_shift_q == csum_q);
                    state_d = csum_ok ? RUN : ERROR;
                end
            end
            RUN:     if (prog_rise) state_d = CNT_LO;
            ERROR:   if (prog_rise) state_d = CNT_LO;
            default: state_d = IDLE;
        endcase

        if (frame_err_q && loading) begin
            state_d = ERROR;
        end

        // Every fresh load starts from address 0 with an empty checksum.
        if (state_d == CNT_LO && state_q != CNT_LO) begin
            csum_d = 8'd0;
            addr_d = '0;
            idx_d  = '0;
        end

        done_d = (state_d == RUN) && (done_q || csum_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'd0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_lo_q    <= 8'd0;
            words_q     <= 16'd0;
            idx_q       <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            csum_q      <= 8'd0;
            done_q      <= 1'b0;
            prog_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            csum_q      <= csum_d;
            done_q      <= done_d;
            prog_prev_q <= prog_prev_d;
        end
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign prog_rst_no = (state_q == RUN);
    assign done_o      = done_q;
    assign err_o       = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader
`timescale 1ns/1ps
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        prog_i;
    logic        rx_i;
    logic [15:0] cpb;

    logic        we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o;
    logic        prog_rst_no, done_o, err_o;

    logic        we2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic        prst2, done2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [1:0]  wr2_addr[$];
    logic [31:0] wr2_data[$];
    int we_run = 0;
    int we_run_max = 0;

    always #5 clk = ~clk;

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DIV_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .prog_i(prog_i), .clks_per_bit_i(cpb), .rx_i(rx_i),
        .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .prog_rst_no(prog_rst_no), .done_o(done_o), .err_o(err_o)
    );

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .DIV_WIDTH(16)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_ni), .prog_i(prog_i), .clks_per_bit_i(cpb), .rx_i(rx_i),
        .we_o(we2), .addr_o(addr2), .wdata_o(wdata2),
        .prog_rst_no(prst2), .done_o(done2), .err_o(err2)
    );

    always @(negedge clk) begin
        if (we_o) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(wdata_o);
            we_run = we_run + 1;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
        if (we2) begin
            wr2_addr.push_back(addr2);
            wr2_data.push_back(wdata2);
        end
    end

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr2_addr.delete();
        wr2_data.delete();
        we_run_max = 0;
    endtask

    task automatic do_reset(input logic p);
        rst_ni = 1'b0;
        prog_i = p;
        rx_i   = 1'b1;
        @(negedge clk);
        clear_logs();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = frame[i];
            repeat (int'(cpb)) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (int'(cpb)) @(negedge clk);
    endtask

    task automatic send_stream(input bq_t s);
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic pulse_prog();
        prog_i = 1'b0;
        repeat (2) @(negedge clk);
        prog_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cpb = 16'd4;
        rst_ni = 1'b0;
        prog_i = 1'b0;
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b expected 0", we_o); end
        n_checks++; if (addr_o !== 12'd0) begin n_fail++; $display("FAIL reset_addr got %h expected 000", addr_o); end
        n_checks++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h expected 0", wdata_o); end
        n_checks++; if (prog_rst_no !== 1'b0) begin n_fail++; $display("FAIL reset_prog_rst_n got %b expected 0", prog_rst_no); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err_o); end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (prog_rst_no !== 1'b1) begin n_fail++; $display("FAIL run_cycle2 got %b expected 1", prog_rst_no); end
        repeat (20) @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL run_no_done got %b expected 0", done_o); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL run_no_we got %0d writes expected 0", wr_addr.size()); end
    endtask

    task automatic test_good_load();
        bq_t s;
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        do_reset(1'b1);
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_addr.size() !== 2) begin
            n_fail++; $display("FAIL good_wr_count got %0d expected 2", wr_addr.size());
        end else begin
            n_checks++; if (wr_addr[0] !== 12'd0) begin n_fail++; $display("FAIL good_addr0 got %h expected 000", wr_addr[0]); end
            n_checks++; if (wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL good_data0 got %h expected 00000013", wr_data[0]); end
            n_checks++; if (wr_addr[1] !== 12'd1) begin n_fail++; $display("FAIL good_addr1 got %h expected 001", wr_addr[1]); end
            n_checks++; if (wr_data[1] !== 32'h0000_006F) begin n_fail++; $display("FAIL good_data1 got %h expected 0000006f", wr_data[1]); end
        end
        n_checks++; if (we_run_max !== 1) begin n_fail++; $display("FAIL good_we_width got %0d expected 1", we_run_max); end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL good_done got %b expected 1", done_o); end
        n_checks++; if (prog_rst_no !== 1'b1) begin n_fail++; $display("FAIL good_prog_rst_n got %b expected 1", prog_rst_no); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL good_err got %b expected 0", err_o); end
    endtask

    task automatic test_reprogram();
        bq_t s;
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        pulse_prog();
        n_checks++; if (prog_rst_no !== 1'b0) begin n_fail++; $display("FAIL reprog_rst_n got %b expected 0", prog_rst_no); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reprog_done_clr got %b expected 0", done_o); end
        clear_logs();
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_addr.size() !== 1) begin
            n_fail++; $display("FAIL reprog_wr_count got %0d expected 1", wr_addr.size());
        end else begin
            n_checks++; if (wr_addr[0] !== 12'd0) begin n_fail++; $display("FAIL reprog_addr got %h expected 000", wr_addr[0]); end
            n_checks++; if (wr_data[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL reprog_data got %h expected 12345678", wr_data[0]); end
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL reprog_done got %b expected 1", done_o); end
    endtask

    task automatic test_bad_csum();
        bq_t s;
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        do_reset(1'b1);
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL csum_err got %b expected 1", err_o); end
        n_checks++; if (prog_rst_no !== 1'b0) begin n_fail++; $display("FAIL csum_rst_n got %b expected 0", prog_rst_no); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL csum_done got %b expected 0", done_o); end
        pulse_prog();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL csum_retry_err got %b expected 0", err_o); end
        clear_logs();
        s[10] = 8'h82;
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL csum_retry_done got %b expected 1", done_o); end
        n_checks++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL csum_retry_count got %0d expected 2", wr_addr.size()); end
    endtask

    task automatic test_framing();
        bq_t s;
        s = '{8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        do_reset(1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b0);
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL frame_err got %b expected 1", err_o); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL frame_no_we got %0d writes expected 0", wr_addr.size()); end
        n_checks++; if (prog_rst_no !== 1'b0) begin n_fail++; $display("FAIL frame_rst_n got %b expected 0", prog_rst_no); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL frame_done got %b expected 0", done_o); end
    endtask

    task automatic test_glitch();
        bq_t s;
        s = '{8'h01, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hAA};
        cpb = 16'd8;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        rx_i = 1'b0;
        @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL glitch_err got %b expected 0", err_o); end
        n_checks++; if (prog_rst_no !== 1'b0) begin n_fail++; $display("FAIL glitch_rst_n got %b expected 0", prog_rst_no); end
        send_stream(s);
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_data.size() !== 1) begin
            n_fail++; $display("FAIL glitch_wr_count got %0d expected 1", wr_data.size());
        end else begin
            n_checks++; if (wr_data[0] !== 32'h0000_00AA) begin n_fail++; $display("FAIL glitch_data got %h expected 000000aa", wr_data[0]); end
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL glitch_done got %b expected 1", done_o); end
        cpb = 16'd4;
    endtask

    task automatic test_reset_mid();
        bq_t s;
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        do_reset(1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        rx_i = 1'b0;
        repeat (6) @(negedge clk);
        rst_ni = 1'b0;
        rx_i = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL midrst_no_we got %0d writes expected 0", wr_addr.size()); end
        do_reset(1'b1);
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_data.size() !== 2) begin
            n_fail++; $display("FAIL midrst_wr_count got %0d expected 2", wr_data.size());
        end else begin
            n_checks++; if (wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL midrst_data0 got %h expected 00000013", wr_data[0]); end
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL midrst_done got %b expected 1", done_o); end
    endtask

    task automatic test_addr_wrap();
        bq_t s;
        logic [1:0] exp_addr[5];
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        s = '{8'h05, 8'h00};
        for (int w = 1; w <= 5; w++) begin
            s.push_back(8'(w));
            s.push_back(8'h00);
            s.push_back(8'h00);
            s.push_back(8'h00);
        end
        s.push_back(8'h0F);
        do_reset(1'b1);
        send_stream(s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr2_addr.size() !== 5) begin
            n_fail++; $display("FAIL wrap_wr_count got %0d expected 5", wr2_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr2_addr[i] !== exp_addr[i]) begin
                    n_fail++; $display("FAIL wrap_addr%0d got %0d expected %0d", i, wr2_addr[i], exp_addr[i]);
                end
                n_checks++;
                if (wr2_data[i] !== 32'(i + 1)) begin
                    n_fail++; $display("FAIL wrap_data%0d got %h expected %h", i, wr2_data[i], 32'(i + 1));
                end
            end
        end
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b expected 1", done2); end
    endtask

    initial begin
        rst_ni = 1'b0;
        prog_i = 1'b0;
        rx_i   = 1'b1;
        cpb    = 16'd4;
        test_reset();
        test_good_load();
        test_reprogram();
        test_bad_csum();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_addr_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
